fifo_level_monitor: RTL and testbench

//  Multi-channel successor to the single-FIFO ready check. Watches NUM_CH FIFO fill levels and

---
 rtl/fifo_mon_pkg.sv | 32 +++
 rtl/fifo_level_chan.sv | 87 ++++++++
 rtl/fifo_level_monitor.sv | 131 +++++++++++++
 tb/tb_fifo_level_monitor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mon_pkg
// Description : Shared types and constants for the multi-channel FIFO level
//               monitor: index-width helper, selector state encoding and the
//               recommended default thresholds.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_mon_pkg;

  // Recommended threshold settings (arm at 514, disarm below 512)
  localparam int READY_HI_DEF = 514;
  localparam int READY_LO_DEF = 512;

  // Round-robin selector states
  typedef enum logic [0:0] {
    SEL_IDLE  = 1'b0,
    SEL_OFFER = 1'b1
  } sel_state_e;

  // Bits needed to index n items; never less than one bit
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the channel index output
  function automatic int ch_idx_w(input int num_ch);
    return idx_w(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_level_chan.sv
`default_nettype none
// ============================================================================
// Module      : fifo_level_chan
// Description : One monitored FIFO channel. Hysteresis compare against the
//               arm / effective disarm thresholds, debounce counter and an
//               optional sticky overflow flag.
//               Optional feature macro: FIFO_MON_OVF_EN (overflow flag).
// Ports       : clk, reset      - clock, async active-high reset
//               level           - this channel's fill level
//               hi_thresh       - arm threshold
//               lo_eff          - disarm threshold, already clamped to <= hi
//               err_clr         - clears the sticky overflow flag
//               ready           - debounced ready flag
//               ovf_err         - sticky overflow flag (0 when feature off)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_level_chan
  import fifo_mon_pkg::*;
#(
  parameter int LEVEL_W    = 11,
  parameter int STABLE_CYC = 1,
  parameter int MAX_LEVEL  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic [LEVEL_W-1:0] hi_thresh,
  input  logic [LEVEL_W-1:0] lo_eff,
  input  logic               err_clr,
  output logic               ready,
  output logic               ovf_err
);

  localparam int               CNT_W    = idx_w(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic             r_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cond;

  // Arm against hi while not ready, hold against lo once ready
  assign w_cond = r_ready ? (level >= lo_eff) : (level >= hi_thresh);

  // The counter toggles ready on reaching CNT_LAST, so it can never pass it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else if (w_cond == r_ready) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_ready <= ~r_ready;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ready = r_ready;

`ifdef FIFO_MON_OVF_EN
  localparam logic [LEVEL_W:0] MAX_L = (LEVEL_W + 1)'(MAX_LEVEL);

  logic r_ovf;

  // A new overflow takes priority over a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if ({1'b0, level} > MAX_L) begin
      r_ovf <= 1'b1;
    end else if (err_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf_err = r_ovf;
`else
  localparam int unused_max_level = MAX_LEVEL;
  logic          unused_err_clr;

  assign unused_err_clr = err_clr;
  assign ovf_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_level_monitor.sv
`default_nettype none
// ============================================================================
// Module      : fifo_level_monitor
// Description : Watches NUM_CH FIFO fill levels, produces per-channel
//               debounced ready flags with runtime hysteresis thresholds and
//               offers ready channels round-robin on a valid/ack port.
//               Optional feature macro: FIFO_MON_OVF_EN (sticky overflow).
// Ports       : clk, reset      - clock, async active-high reset
//               fifo_num        - packed levels, ch i at [i*LEVEL_W +: LEVEL_W]
//               hi_thresh       - arm threshold
//               lo_thresh       - disarm threshold (clamped to hi_thresh)
//               fifo_ready      - per-channel debounced ready
//               sel_valid       - a ready channel is offered
//               sel_ch          - offered channel index
//               sel_ack         - consumer accepts the offer
//               err_clr         - per-channel overflow clear
//               ovf_err         - per-channel sticky overflow
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_level_monitor
  import fifo_mon_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int LEVEL_W    = 11,
  parameter  int STABLE_CYC = 1,
  parameter  int MAX_LEVEL  = 1024,
  localparam int CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*LEVEL_W-1:0] fifo_num,
  input  logic [LEVEL_W-1:0]        hi_thresh,
  input  logic [LEVEL_W-1:0]        lo_thresh,
  output logic [NUM_CH-1:0]         fifo_ready,
  output logic                      sel_valid,
  output logic [CH_W-1:0]           sel_ch,
  input  logic                      sel_ack,
  input  logic [NUM_CH-1:0]         err_clr,
  output logic [NUM_CH-1:0]         ovf_err
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  logic [LEVEL_W-1:0] w_lo_eff;

  // A lo above hi would invert the hysteresis; clamp it to hi instead
  assign w_lo_eff = (lo_thresh < hi_thresh) ? lo_thresh : hi_thresh;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    fifo_level_chan #(
      .LEVEL_W    (LEVEL_W),
      .STABLE_CYC (STABLE_CYC),
      .MAX_LEVEL  (MAX_LEVEL)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .level     (fifo_num[gi*LEVEL_W +: LEVEL_W]),
      .hi_thresh (hi_thresh),
      .lo_eff    (w_lo_eff),
      .err_clr   (err_clr[gi]),
      .ready     (fifo_ready[gi]),
      .ovf_err   (ovf_err[gi])
    );
  end

  sel_state_e      r_state;
  sel_state_e      w_state_nxt;
  logic [CH_W-1:0] r_sel_ch;
  logic [CH_W-1:0] w_sel_ch_nxt;
  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_ptr_nxt;
  logic            w_found;
  logic [CH_W-1:0] w_pick;

  // First ready channel at or above ptr, wrapping past the last channel
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_CH) begin
        j = j - NUM_CH;
      end
      if (!w_found && fifo_ready[j]) begin
        w_found = 1'b1;
        w_pick  = CH_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= SEL_IDLE;
      r_sel_ch <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel_ch <= w_sel_ch_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  // The offer is frozen until ack even if its channel loses ready
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_ch_nxt = r_sel_ch;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      SEL_IDLE: begin
        if (w_found) begin
          w_sel_ch_nxt = w_pick;
          w_state_nxt  = SEL_OFFER;
        end
      end
      SEL_OFFER: begin
        if (sel_ack) begin
          w_state_nxt = SEL_IDLE;
          w_ptr_nxt   = (r_sel_ch == CH_LAST) ? '0 : r_sel_ch + 1'b1;
        end
      end
      default: w_state_nxt = SEL_IDLE;
    endcase
  end

  assign sel_valid = (r_state == SEL_OFFER);
  assign sel_ch    = r_sel_ch;

endmodule
`default_nettype wire

// File: tb/tb_fifo_level_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_level_monitor
// Description : Self-checking bench. Two monitors (debounce 1 and 4) share
//               the stimulus; a behavioural model tracks both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_level_monitor;

  localparam int NCH  = 4;
  localparam int LW   = 11;
  localparam int MAXL = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [LW-1:0]  lvl [NCH];
  logic [LW-1:0]  hi;
  logic [LW-1:0]  lo;
  logic           ack;
  logic [NCH-1:0] clr;
  wire  [NCH*LW-1:0] fnum = {lvl[3], lvl[2], lvl[1], lvl[0]};

  logic [NCH-1:0] rdy0, rdy1, ovf0, ovf1;
  logic           sv0, sv1;
  logic [1:0]     sch0, sch1;

  fifo_level_monitor #(.NUM_CH(NCH), .LEVEL_W(LW), .STABLE_CYC(1), .MAX_LEVEL(MAXL)) u_dut0 (
    .clk(clk), .reset(reset), .fifo_num(fnum), .hi_thresh(hi), .lo_thresh(lo),
    .fifo_ready(rdy0), .sel_valid(sv0), .sel_ch(sch0), .sel_ack(ack),
    .err_clr(clr), .ovf_err(ovf0));

  fifo_level_monitor #(.NUM_CH(NCH), .LEVEL_W(LW), .STABLE_CYC(4), .MAX_LEVEL(MAXL)) u_dut1 (
    .clk(clk), .reset(reset), .fifo_num(fnum), .hi_thresh(hi), .lo_thresh(lo),
    .fifo_ready(rdy1), .sel_valid(sv1), .sel_ch(sch1), .sel_ack(ack),
    .err_clr(clr), .ovf_err(ovf1));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_rdy    [2][NCH];
  int m_streak [2][NCH];
  bit m_off    [2];
  int m_ch     [2];
  int m_ptr    [2];
  bit m_ovf    [NCH];

  function automatic int stab(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_off[d] = 0; m_ch[d] = 0; m_ptr[d] = 0;
      for (int i = 0; i < NCH; i++) begin
        m_rdy[d][i] = 0; m_streak[d][i] = 0;
      end
    end
    for (int i = 0; i < NCH; i++) m_ovf[i] = 0;
  endtask

  function automatic int obs_rdy(input int d);
    return (d == 0) ? int'(rdy0) : int'(rdy1);
  endfunction
  function automatic int obs_sv(input int d);
    return (d == 0) ? int'(sv0) : int'(sv1);
  endfunction
  function automatic int obs_ch(input int d);
    return (d == 0) ? int'(sch0) : int'(sch1);
  endfunction
  function automatic int obs_ovf(input int d);
    return (d == 0) ? int'(ovf0) : int'(ovf1);
  endfunction

  task automatic check_all(input string where);
    int er, eo;
    for (int d = 0; d < 2; d++) begin
      er = 0; eo = 0;
      for (int i = 0; i < NCH; i++) begin
        if (m_rdy[d][i]) er |= (1 << i);
        if (m_ovf[i])    eo |= (1 << i);
      end
      check_val($sformatf("d%0d_%s_ready", d, where), obs_rdy(d), er);
      check_val($sformatf("d%0d_%s_valid", d, where), obs_sv(d), int'(m_off[d]));
      check_val($sformatf("d%0d_%s_selch", d, where), obs_ch(d), m_ch[d]);
      check_val($sformatf("d%0d_%s_ovf",   d, where), obs_ovf(d), eo);
    end
  endtask

  // Advance the model by one edge from the inputs currently applied,
  // then compare after the edge.
  task automatic step();
    int  lo_e, j, lv;
    bit  want, found;
    lo_e = (int'(lo) < int'(hi)) ? int'(lo) : int'(hi);
    for (int d = 0; d < 2; d++) begin
      if (!m_off[d]) begin
        found = 0;
        for (int k = 0; k < NCH; k++) begin
          j = (m_ptr[d] + k) % NCH;
          if (!found && m_rdy[d][j]) begin
            found = 1; m_off[d] = 1; m_ch[d] = j;
          end
        end
      end else if (ack) begin
        m_off[d] = 0;
        m_ptr[d] = (m_ch[d] + 1) % NCH;
      end
      for (int i = 0; i < NCH; i++) begin
        lv   = int'(lvl[i]);
        want = m_rdy[d][i] ? (lv >= lo_e) : (lv >= int'(hi));
        if (want != m_rdy[d][i]) begin
          m_streak[d][i]++;
          if (m_streak[d][i] >= stab(d)) begin
            m_rdy[d][i]    = want;
            m_streak[d][i] = 0;
          end
        end else begin
          m_streak[d][i] = 0;
        end
      end
    end
`ifdef FIFO_MON_OVF_EN
    for (int i = 0; i < NCH; i++) begin
      if (int'(lvl[i]) > MAXL) m_ovf[i] = 1;
      else if (clr[i])         m_ovf[i] = 0;
    end
`endif
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NCH; i++) lvl[i] = LW'(v);
  endtask

  localparam int NPICK = 10;
  int picks [NPICK] = '{0, 511, 512, 513, 514, 515, 600, 1000, 1025, 2047};

  initial begin
    int offers [5];
    int n_off;
    bit prev_sv;

    reset = 1'b1;
    set_all(0);
    hi = LW'(514); lo = LW'(512); ack = 1'b0; clr = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // 1: single-cycle debounce arm/hold/disarm on ch0
    lvl[0] = LW'(513); step(); check_val("t1_513_not_ready", int'(rdy0[0]), 0);
    lvl[0] = LW'(514); step(); check_val("t1_514_ready",     int'(rdy0[0]), 1);
    lvl[0] = LW'(513); step(); check_val("t1_513_hold",      int'(rdy0[0]), 1);
    lvl[0] = LW'(511); step(); check_val("t1_511_drop",      int'(rdy0[0]), 0);

    // 2: four-cycle debounce on ch1
    do_reset();
    lvl[1] = LW'(600);
    repeat (3) step();
    check_val("t2_3cyc_not_ready", int'(rdy1[1]), 0);
    lvl[1] = LW'(0); step();
    check_val("t2_glitch_ignored", int'(rdy1[1]), 0);
    lvl[1] = LW'(600);
    repeat (3) step();
    check_val("t2_before_4th", int'(rdy1[1]), 0);
    step();
    check_val("t2_after_4th", int'(rdy1[1]), 1);

    // 3: all ready, ack every offer
    do_reset();
    set_all(600); ack = 1'b1;
    n_off = 0; prev_sv = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (sv0 && !prev_sv && n_off < 5) begin
        offers[n_off] = int'(sch0);
        n_off++;
      end
      prev_sv = sv0;
    end
    check_val("t3_offer_count", n_off, 5);
    for (int k = 0; k < 5; k++) check_val($sformatf("t3_offer%0d", k), offers[k], k % NCH);

    // 4: offer held while its channel drops, next offer skips it
    ack = 1'b0;
    do_reset();
    set_all(0); lvl[2] = LW'(600);
    repeat (3) step();
    check_val("t4_valid", int'(sv0), 1);
    check_val("t4_ch2", int'(sch0), 2);
    lvl[2] = LW'(0); lvl[3] = LW'(600);
    repeat (3) step();
    check_val("t4_held_valid", int'(sv0), 1);
    check_val("t4_held_ch", int'(sch0), 2);
    check_val("t4_ch2_dropped", int'(rdy0[2]), 0);
    ack = 1'b1; step(); ack = 1'b0;
    check_val("t4_bubble", int'(sv0), 0);
    step();
    check_val("t4_next_ch", int'(sch0), 3);

    // 5: lo above hi clamps to hi; reset during an offer
    do_reset();
    set_all(0); hi = LW'(514); lo = LW'(700);
    lvl[0] = LW'(600); step();
    check_val("t5_arm", int'(rdy0[0]), 1);
    lvl[0] = LW'(520); step();
    check_val("t5_hold_lo_clamped", int'(rdy0[0]), 1);
    lvl[0] = LW'(513); step();
    check_val("t5_drop", int'(rdy0[0]), 0);
    lo = LW'(512);
    lvl[0] = LW'(600); step(); step();
    check_val("t5_offer_before_rst", int'(sv0), 1);
    do_reset();
    check_val("t5_rst_valid", int'(sv0), 0);

    // 6: overflow flag
    set_all(0);
    lvl[0] = LW'(1025); step();
`ifdef FIFO_MON_OVF_EN
    check_val("t6_ovf_set", int'(ovf0[0]), 1);
    lvl[0] = LW'(1000); step();
    check_val("t6_sticky", int'(ovf0[0]), 1);
    lvl[0] = LW'(1025); clr = 4'b0001; step();
    check_val("t6_set_wins", int'(ovf0[0]), 1);
    lvl[0] = LW'(1000); step();
    check_val("t6_cleared", int'(ovf0[0]), 0);
`else
    check_val("t6_ovf_off", int'(ovf0), 0);
    clr = 4'b1111; step();
    check_val("t6_ovf_off_clr", int'(ovf0), 0);
`endif
    clr = '0;

    // Randomised traffic
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(3) == 0) lvl[i] = LW'(picks[$urandom_range(NPICK - 1)]);
      if (c % 60 == 0) begin
        case ($urandom_range(5))
          0:       begin hi = LW'(514);  lo = LW'(700);  end
          1:       begin hi = LW'(600);  lo = LW'(300);  end
          2:       begin hi = LW'(0);    lo = LW'(0);    end
          3:       begin hi = LW'(2047); lo = LW'(2047); end
          default: begin hi = LW'(514);  lo = LW'(512);  end
        endcase
      end
      ack = 1'($urandom_range(1));
      clr = ($urandom_range(7) == 0) ? NCH'($urandom) : '0;
      if ($urandom_range(399) == 0) do_reset();
      else                          step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
